// File: rtl/gf4_share_pkg.sv
// Shared constants and helpers for the masked GF(2^2) square-and-refresh stage.
// Field elements use the polynomial basis of x^2+x+1.
package gf4_share_pkg;

    localparam int unsigned SHARE_W  = 2;
    localparam int unsigned N_SHARES = 3;
    localparam int unsigned RND_W    = 4;

    // Mask selectors: bit 0 selects r[1:0], bit 1 selects r[3:2].
    localparam logic [1:0] MASK_SEL_S1 = 2'b01;
    localparam logic [1:0] MASK_SEL_S2 = 2'b10;
    localparam logic [1:0] MASK_SEL_S3 = 2'b11;

    // Squaring is linear in characteristic 2: (a1*x + a0)^2 = a1*x + (a1 ^ a0).
    function automatic logic [SHARE_W-1:0] gf4_sq(input logic [SHARE_W-1:0] a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    function automatic logic [SHARE_W-1:0] share_mask(input logic [1:0]       sel,
                                                      input logic [RND_W-1:0] rnd);
        logic [SHARE_W-1:0] m;
        m = '0;
        if (sel[0]) m = m ^ rnd[1:0];
        if (sel[1]) m = m ^ rnd[3:2];
        return m;
    endfunction

endpackage

// File: rtl/gf4_share_fifo.sv
// Storage for a single share: DEPTH entries, one write port and one read port.
// Pointers come from the shared control in the top level.
module gf4_share_fifo
    import gf4_share_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [PTR_W-1:0]   wr_ptr,
    input  logic [SHARE_W-1:0] wdata,
    input  logic [PTR_W-1:0]   rd_ptr,
    output logic [SHARE_W-1:0] rdata
);

    logic [SHARE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (we) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/gf4_sq_refresh_stage.sv
// Share-wise GF(2^2) squaring with fresh re-masking, buffered in a small FIFO.
// The three shares never meet except through the mask XORs on the write side.
module gf4_sq_refresh_stage
    import gf4_share_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SHARE_W-1:0] in_s1,
    input  logic [SHARE_W-1:0] in_s2,
    input  logic [SHARE_W-1:0] in_s3,
    input  logic [RND_W-1:0]   r,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SHARE_W-1:0] out_s1,
    output logic [SHARE_W-1:0] out_s2,
    output logic [SHARE_W-1:0] out_s3,
    output logic [CNT_W-1:0]   xfer_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [SHARE_W-1:0] w1, w2, w3;
    logic [SHARE_W-1:0] rd1, rd2, rd3;

    // Ready ignores out_ready on purpose: a full FIFO never accepts, even while popping.
    assign in_ready  = (count < OCC_W'(DEPTH)) & ~flush & rst_n;
    assign out_valid = (count != '0) & rst_n;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign w1 = gf4_sq(in_s1) ^ share_mask(MASK_SEL_S1, r);
    assign w2 = gf4_sq(in_s2) ^ share_mask(MASK_SEL_S2, r);
    assign w3 = gf4_sq(in_s3) ^ share_mask(MASK_SEL_S3, r);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            xfer_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
            if (push && (xfer_cnt != '1)) xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

    gf4_share_fifo #(.DEPTH(DEPTH)) u_fifo_s1 (
        .clk(clk), .rst_n(rst_n), .we(push), .wr_ptr(wr_ptr), .wdata(w1),
        .rd_ptr(rd_ptr), .rdata(rd1)
    );

    gf4_share_fifo #(.DEPTH(DEPTH)) u_fifo_s2 (
        .clk(clk), .rst_n(rst_n), .we(push), .wr_ptr(wr_ptr), .wdata(w2),
        .rd_ptr(rd_ptr), .rdata(rd2)
    );

    gf4_share_fifo #(.DEPTH(DEPTH)) u_fifo_s3 (
        .clk(clk), .rst_n(rst_n), .we(push), .wr_ptr(wr_ptr), .wdata(w3),
        .rd_ptr(rd_ptr), .rdata(rd3)
    );

    // Idle outputs are forced to zero so stale storage is never exposed.
    assign out_s1 = out_valid ? rd1 : '0;
    assign out_s2 = out_valid ? rd2 : '0;
    assign out_s3 = out_valid ? rd3 : '0;

endmodule

// File: tb/tb_gf4_sq_refresh_stage.sv
// Scoreboard bench for gf4_sq_refresh_stage: a queue-based reference FIFO with
// table-driven GF(2^2) squaring, and a monitor that checks every delivered entry.
module tb_gf4_sq_refresh_stage;

    localparam int DEPTH   = 2;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, out_ready;
    logic [1:0]       in_s1, in_s2, in_s3;
    logic [3:0]       r;
    logic             in_ready, out_valid;
    logic [1:0]       out_s1, out_s2, out_s3;
    logic [CNT_W-1:0] xfer_cnt;

    gf4_sq_refresh_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3), .r(r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] e1, e2, e3, plain;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   errors = 0;
    int   checks = 0;
    int   occ = 0;
    int   xfer_m = 0;
    int   pushes_since_rst = 0;
    bit   acc, pp;

    // Squares in GF(4): 0->0, 1->1, x->x+1, x+1->x.
    function automatic logic [1:0] sq_ref(input logic [1:0] a);
        case (a)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            2'd2:    return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference FIFO: accepts while not full, delivers while not empty.
    always @(posedge clk) begin
        if (!rst_n) begin
            occ = 0; xfer_m = 0; pushes_since_rst = 0;
            q.delete();
        end else if (flush) begin
            occ = 0;
            q.delete();
        end else begin
            acc = in_valid && (occ < DEPTH);
            pp  = (occ != 0) && out_ready;
            if (acc) begin
                q.push_back('{e1:    sq_ref(in_s1) ^ r[1:0],
                              e2:    sq_ref(in_s2) ^ r[3:2],
                              e3:    sq_ref(in_s3) ^ r[1:0] ^ r[3:2],
                              plain: sq_ref(in_s1 ^ in_s2 ^ in_s3)});
                pushes_since_rst++;
                if (xfer_m < CNT_MAX) xfer_m++;
            end
            occ = occ + int'(acc) - int'(pp);
        end
    end

    // Monitor: handshake/counter checks each cycle, payload check on every pop.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("in_ready", int'(in_ready), int'((occ < DEPTH) && !flush && rst_n));
            chk("out_valid", int'(out_valid), int'((occ != 0) && rst_n));
            chk("xfer_cnt", int'(xfer_cnt), xfer_m);
            if (!out_valid) begin
                chk("idle_shares", int'({out_s1, out_s2, out_s3}), 0);
            end else if (out_ready && !flush && rst_n) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_underflow: DUT delivered %0h/%0h/%0h with nothing expected",
                             out_s1, out_s2, out_s3);
                end else begin
                    e_mon = q.pop_front();
                    chk("out_s1", int'(out_s1), int'(e_mon.e1));
                    chk("out_s2", int'(out_s2), int'(e_mon.e2));
                    chk("out_s3", int'(out_s3), int'(e_mon.e3));
                    chk("share_xor", int'(out_s1 ^ out_s2 ^ out_s3), int'(e_mon.plain));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        {in_s1, in_s2, in_s3, r} = 10'($urandom);
    endtask

    initial begin
        int budget;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_s1 = '0; in_s2 = '0; in_s3 = '0; r = '0;
        repeat (3) step();
        rst_n = 1'b1;

        // Known-answer pushes.
        in_valid = 1'b1; in_s1 = 2'b01; in_s2 = 2'b11; in_s3 = 2'b00; r = 4'b0110;
        step();
        in_valid = 1'b0; #1;
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_s1", int'(out_s1), 3);
        chk("t1_s2", int'(out_s2), 3);
        chk("t1_s3", int'(out_s3), 3);
        chk("t1_xfer", int'(xfer_cnt), 1);
        out_ready = 1'b1; in_valid = 1'b1; r = 4'b0000;
        step();
        in_valid = 1'b0; #1;
        chk("t2_s1", int'(out_s1), 1);
        chk("t2_s2", int'(out_s2), 2);
        chk("t2_s3", int'(out_s3), 0);
        step();
        out_ready = 1'b0;

        // Back-pressure: third push refused while full.
        in_valid = 1'b1;
        repeat (3) begin rand_in(); step(); end
        in_valid = 1'b0; #1;
        chk("t3_xfer", int'(xfer_cnt), 4);
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;

        // Streaming at occupancy 1.
        in_valid = 1'b1; rand_in();
        step();
        out_ready = 1'b1;
        repeat (10) begin rand_in(); step(); end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0; #1;
        chk("t4_xfer", int'(xfer_cnt), 15);

        // Flush with in_valid held, then reset mid-stream.
        in_valid = 1'b1;
        repeat (2) begin rand_in(); step(); end
        flush = 1'b1; rand_in();
        step();
        flush = 1'b0; in_valid = 1'b0; #1;
        chk("t5_valid", int'(out_valid), 0);
        chk("t5_ready", int'(in_ready), 1);
        chk("t5_xfer", int'(xfer_cnt), 17);
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) begin rand_in(); out_ready = 1'($urandom); step(); end
        rst_n = 1'b0;
        step();
        #1;
        chk("t5_rst_valid", int'(out_valid), 0);
        chk("t5_rst_shares", int'({out_s1, out_s2, out_s3}), 0);
        chk("t5_rst_xfer", int'(xfer_cnt), 0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();

        // Random traffic, then full-rate streaming up to counter saturation.
        repeat (3000) begin
            rand_in();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        budget = 80000;
        while (pushes_since_rst < 65536 && budget > 0) begin
            rand_in();
            step();
            budget--;
        end
        if (budget == 0) begin
            checks++; errors++;
            $display("FAIL sat_timeout: pushes %0d required 65536", pushes_since_rst);
        end
        in_valid = 1'b0;
        repeat (3) step();
        #1;
        chk("t6_sat", int'(xfer_cnt), CNT_MAX);
        chk("t6_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
